// File: rtl/key_demux.sv
// key_demux: routes each accepted (key, data) word from a single producer to
// the output channel selected by the key. Every channel has its own circular
// FIFO, so a stalled consumer only blocks traffic addressed to that channel.
// Words with a key at or above NR_OUT are consumed and counted as drops.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready depends only on in_key and
//                         registered occupancy (never on out_ready)
//   in_key, in_data       destination channel index and payload
//   out_valid[n]          channel n head entry valid
//   out_ready[n]          consumer n takes the head entry
//   out_data              lane n at [DATA_LEN*(n+1)-1 : DATA_LEN*n], 0 when empty
//   drop_cnt              saturating count of out-of-range-key words
module key_demux #(
  parameter int unsigned NR_OUT   = 4,
  parameter int unsigned KEY_LEN  = 2,
  parameter int unsigned DATA_LEN = 2,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [KEY_LEN-1:0]         in_key,
  input  logic [DATA_LEN-1:0]        in_data,
  output logic [NR_OUT-1:0]          out_valid,
  input  logic [NR_OUT-1:0]          out_ready,
  output logic [NR_OUT*DATA_LEN-1:0] out_data,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned KEYS  = 1 << KEY_LEN;

  logic            w_key_ok;
  logic [KEYS-1:0] w_full;
  logic            w_accept;
  logic [7:0]      r_drop_cnt;

  // Full flags are padded to the whole key space so in_key never indexes out of range.
  assign w_key_ok = ({1'b0, in_key} < (KEY_LEN + 1)'(NR_OUT));
  assign in_ready = w_key_ok ? ~w_full[in_key] : 1'b1;
  assign w_accept = in_valid & in_ready;

  genvar g;
  generate
    for (g = 0; g < KEYS; g++) begin : g_chan
      if (g < NR_OUT) begin : g_fifo
        logic [DATA_LEN-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]    r_wr_ptr;
        logic [PTR_W-1:0]    r_rd_ptr;
        logic [CNT_W-1:0]    r_count;
        logic                w_push;
        logic                w_pop;

        assign w_push       = w_accept & (in_key == KEY_LEN'(g));
        assign out_valid[g] = (r_count != '0);
        assign w_pop        = out_valid[g] & out_ready[g];
        assign w_full[g]    = (r_count == CNT_W'(DEPTH));

        // Empty lanes read 0 so stale storage never leaks after reset.
        assign out_data[DATA_LEN*g +: DATA_LEN] = out_valid[g] ? r_mem[r_rd_ptr] : '0;

        // Pointers wrap naturally because DEPTH is a power of two.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
          end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
              2'b10:   r_count <= r_count + CNT_W'(1);
              2'b01:   r_count <= r_count - CNT_W'(1);
              default: r_count <= r_count;
            endcase
          end
        end

        // Storage needs no reset; the lane is masked while the channel is empty.
        always_ff @(posedge clk) begin
          if (w_push) r_mem[r_wr_ptr] <= in_data;
        end
      end else begin : g_none
        assign w_full[g] = 1'b0;
      end
    end
  endgenerate

  // Out-of-range words are always accepted and counted, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else if (in_valid && !w_key_ok && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_key_demux.sv
// tb_key_demux: scoreboard bench for key_demux. A 4-channel instance carries
// routing, backpressure, full+pop, wrap and reset traffic; a 3-channel
// instance receives key 3 words to exercise dropping and drop_cnt saturation.
module tb_key_demux;

  localparam int unsigned DP = 2;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // 4-channel instance
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_key;
  logic [1:0] in_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [7:0] drop_cnt;

  // 3-channel instance
  logic       in3_valid;
  logic       in3_ready;
  logic [1:0] in3_key;
  logic [1:0] in3_data;
  logic [2:0] out3_valid;
  logic [2:0] out3_ready;
  logic [5:0] out3_data;
  logic [7:0] drop3;

  key_demux #(.NR_OUT(4), .KEY_LEN(2), .DATA_LEN(2), .DEPTH(DP)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  key_demux #(.NR_OUT(3), .KEY_LEN(2), .DATA_LEN(2), .DEPTH(DP)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in3_valid), .in_ready(in3_ready), .in_key(in3_key), .in_data(in3_data),
    .out_valid(out3_valid), .out_ready(out3_ready), .out_data(out3_data),
    .drop_cnt(drop3)
  );

  int         n_tests = 0;
  int         n_fail  = 0;

  // Scoreboard: per-channel expected words, occupancy and drop count.
  logic [1:0] q [4][$];
  int         mcnt [4];
  int         exp_drop3;
  logic       exp_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int n = 0; n < 4; n++) begin
      q[n].delete();
      mcnt[n] = 0;
    end
    exp_drop3 = 0;
  endtask

  // One clock: check outputs at negedge, then advance the model at posedge.
  task automatic cycle();
    logic [3:0] ev;
    logic [1:0] ed;
    logic       er;
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      ev[n] = (mcnt[n] != 0);
      if (mcnt[n] != 0) ed = q[n][0];
      else              ed = 2'd0;
      check($sformatf("lane%0d_data", n), 32'(out_data[2*n +: 2]), 32'(ed));
    end
    check("out_valid", 32'(out_valid), 32'(ev));
    er = (mcnt[in_key] < int'(DP));
    check("in_ready", 32'(in_ready), 32'(er));
    check("drop_cnt4", 32'(drop_cnt), 32'd0);
    check("drop_cnt3", 32'(drop3), 32'(exp_drop3));
    check("out3_valid", 32'(out3_valid), 32'd0);
    if (in3_valid) check("in3_ready", 32'(in3_ready), 32'd1);
    exp_acc = in_valid && er;
    @(posedge clk);
    for (int n = 0; n < 4; n++) begin
      if (mcnt[n] > 0 && out_ready[n]) begin
        void'(q[n].pop_front());
        mcnt[n]--;
      end
    end
    if (exp_acc) begin
      q[in_key].push_back(in_data);
      mcnt[in_key]++;
    end
    if (in3_valid && exp_drop3 < 255) exp_drop3++;
    #1;
  endtask

  initial begin
    logic done;
    rst = 1'b1;
    in_valid = 1'b0; in_key = 2'd0; in_data = 2'd0; out_ready = 4'b0000;
    in3_valid = 1'b0; in3_key = 2'd3; in3_data = 2'd0; out3_ready = 3'b111;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_out3_valid", 32'(out3_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Route one word to each channel.
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_key = 2'(k); in_data = 2'(k + 1);
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();

    // Backpressure on channel 2 while channel 1 keeps flowing.
    out_ready = 4'b1011;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_key = 2'd2; in_data = 2'(k);
      cycle();
    end
    in_key = 2'd1; in_data = 2'd3; cycle();
    in_data = 2'd0; cycle();
    out_ready = 4'b1111;
    in_key = 2'd2; in_data = 2'd3;
    done = 1'b0;
    for (int t = 0; t < 8 && !done; t++) begin
      cycle();
      if (exp_acc) done = 1'b1;
    end
    if (!done) check("bp_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    repeat (3) cycle();

    // Channel 0 full, popped and pushed in the same cycle.
    out_ready = 4'b1110;
    in_valid = 1'b1; in_key = 2'd0; in_data = 2'd1; cycle();
    in_data = 2'd2; cycle();
    out_ready = 4'b1111;
    in_data = 2'd3; cycle();
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // Back-to-back push/pop across pointer wraps on channel 3.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_key = 2'd3; in_data = 2'(i * 3 + 1);
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();

    // Out-of-range key on the 3-channel instance.
    in3_valid = 1'b1;
    repeat (300) cycle();
    in3_valid = 1'b0;
    cycle();
    check("drop3_saturated", 32'(drop3), 32'd255);

    // Asynchronous reset with channels 0 and 1 holding data.
    out_ready = 4'b0000;
    in_valid = 1'b1; in_key = 2'd0; in_data = 2'd2; cycle();
    in_key = 2'd1; in_data = 2'd1; cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_data", 32'(out_data), 32'd0);
    check("async_drop3", 32'(drop3), 32'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 4'b1111;
    repeat (3) cycle();
    in_valid = 1'b1; in_key = 2'd2; in_data = 2'd3; cycle();
    in_valid = 1'b0;
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_demux.md
Name: key_demux

Overview:
- Key-addressed stream distributor: the inverse of the key-select mux. One input stream carries a key and a data word. Each accepted word goes to the output channel that the key selects.
- Every output channel has its own small FIFO, so one stalled consumer does not block traffic to the other channels.
- Sits between a single producer (e.g. a decode stage) and up to NR_OUT independent consumers.

Parameters:
- NR_OUT, 4, number of output channels; legal range 2..2^KEY_LEN.
- KEY_LEN, 2, key width in bits.
- DATA_LEN, 2, data word width in bits.
- DEPTH, 2, entries per channel FIFO; must be a power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block will accept the word this cycle.
- in_key  input  KEY_LEN  destination channel index.
- in_data  input  DATA_LEN  payload.
- out_valid  output  NR_OUT  bit n: channel n head entry is valid.
- out_ready  input  NR_OUT  bit n: consumer n takes the head entry.
- out_data  output  NR_OUT*DATA_LEN  channel n data at bits [DATA_LEN*(n+1)-1 : DATA_LEN*n].
- drop_cnt  output  8  saturating count of words dropped because of an out-of-range key.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - all FIFO pointers and occupancy counts go to 0;
  - out_valid = 0, drop_cnt = 0, out_data = 0.
  - FIFO storage contents are don't-care, but out_data must read 0 while its channel is empty.
- Reset mid-traffic: all buffered words are discarded, with no partial delivery. The first accepted word after reset release is the first word delivered.
- Transfer rule: a handshake completes on the rising clk edge where valid and ready are both 1.
- Input acceptance:
  - If in_key < NR_OUT: in_ready = NOT full[in_key].
  - If in_key >= NR_OUT: in_ready = 1 and the word is consumed and dropped. drop_cnt increments by 1 and saturates at 255.
- in_ready is a combinational function of in_key and registered occupancy only. It must never depend on out_ready, so there is no ready pass-through.
  - Consequence: a channel that is full and popped in the same cycle still shows in_ready = 0 that cycle.
- Latency:
  - A word accepted at edge k is visible on out_valid[n] and out_data after edge k (it can be consumed at edge k+1).
  - There is no combinational in-to-out path.
- Each channel FIFO:
  - Circular buffer of DEPTH entries with wr_ptr, rd_ptr and count 0..DEPTH.
  - Pointers wrap from DEPTH-1 to 0.
  - out_valid[n] = (count != 0); out_data lane n = storage[rd_ptr].
  - Push when the input handshake targets n; pop when out_valid[n] and out_ready[n].
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal only when count is between 1 and DEPTH-1, because a push requires not-full.
  - Push into an empty FIFO while out_ready = 1: no bypass; the word appears the next cycle.
- Ordering: per-channel order is strictly FIFO. Ordering across channels is not defined.
- At most one push per cycle across all channels. Pops on different channels are independent and may happen in the same cycle.
- in_valid = 0: no state change except pops. in_key and in_data are ignored.
- out_ready asserted on an empty channel: no effect, and the count must not underflow.

Test Plan:
- Reset then route: push key=0..3 with data 1,2,3,0, all out_ready = 1. Required: out_valid is one-hot in order 0001, 0010, 0100, 1000, one cycle after each accept; each lane carries its word; in_ready stays 1.
- Backpressure: out_ready[2] = 0; push key=2 with data 1, 2, 3. Required:
  - first two words accepted; in_ready drops to 0 at the third (count = 2);
  - key=1 words are still accepted during the stall;
  - after releasing out_ready[2], lane 2 outputs 1, 2, then the third word is accepted and delivered.
- Full plus simultaneous pop: channel 0 full, out_ready[0] = 1, in_valid with key=0. Required: in_ready = 0 that cycle, count becomes 1, and the word is accepted on the next cycle.
- Wrap-around: push and pop 10 words on channel 3 back to back. Required: data sequence is preserved across pointer wraps, no loss and no duplicates.
- Out-of-range key: NR_OUT = 3, KEY_LEN = 2; push key=3 300 times. Required: in_ready = 1 throughout, no out_valid asserted, drop_cnt saturates at 255.
- Async reset mid-operation: with channels 0 and 1 holding data, pulse rst between edges. Required: out_valid = 0 and drop_cnt = 0 immediately, before the next edge; no stale words appear after release.
